seq_pattern_detector: RTL and testbench

//  Parametrised serial bit-pattern detector, the successor to the fixed 10110 Mealy detector.

---
 rtl/seq_pattern_detector.sv | 106 ++++++++++
 tb/tb_seq_pattern_detector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: runtime-loadable pattern/length, overlap select, saturating match count.
// Latency: z and cfg_err are registered one cycle after the completing bit / config request.
// Backpressure: none; en qualifies input bits, and en=0 freezes the shift history.
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0001_0110,
  parameter int                 DEFAULT_LEN = 5,
  localparam int                LEN_W       = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cnt_clr,
  output logic               z,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               z_q, z_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cfg_ok;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               enough_bits;
  logic               hit;

  // Window compare, config validation and next-state selection.
  always_comb begin
    cfg_ok      = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    win         = {hist_q[MAX_LEN-2:0], x};
    mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    // len_q is never zero, so len_q-1 cannot underflow.
    enough_bits = (fill_q >= (len_q - LEN_W'(1)));
    // A legal config load in the same cycle discards the bit, so it can never hit.
    hit         = en && !cfg_ok && enough_bits && (((win ^ pat_q) & mask) == '0);
    fill_inc    = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : (fill_q + LEN_W'(1));

    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    z_d       = hit;
    cfg_err_d = cfg_load && !cfg_ok;
    cnt_d     = cnt_q;

    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = win;
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      fill_d = (hit && !overlap) ? '0 : fill_inc;
    end

    // Clear wins over a simultaneous hit; otherwise count up and stick at all-ones.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= DEFAULT_PAT;
      len_q     <= LEN_W'(DEFAULT_LEN);
      z_q       <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      z_q       <= z_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign z         = z_q;
  assign cfg_err   = cfg_err_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios plus random traffic.
// Outputs are sampled 1ns after each rising edge and compared with a queue-based reference.
// Inputs change right after sampling, so they are stable across the following edge.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN+1);

  logic               clk = 1'b0;
  logic               reset_n;
  logic               en, x, overlap, cfg_load, cnt_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               z, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int errors = 0;
  int checks = 0;
  int zcnt   = 0;
  int ecnt   = 0;

  // Reference model state: received bits since the last clear, and the count of "fresh" bits.
  bit   hq[$];
  int   fresh;
  logic [MAX_LEN-1:0] m_pat;
  int   m_len;
  int   m_cnt;
  bit   m_z, m_err;

  seq_pattern_detector dut (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clr(cnt_clr), .z(z), .cfg_err(cfg_err), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    fresh = 0;
    m_pat = 8'b0001_0110;
    m_len = 5;
    m_cnt = 0;
    m_z   = 0;
    m_err = 0;
  endtask

  // One clock of the reference: the pattern matches when the newest len bits, read back from
  // the most recent, equal pat[0], pat[1], ... and at least len fresh bits have arrived.
  task automatic model_step();
    bit hit;
    bit legal;
    hit   = 0;
    m_z   = 0;
    m_err = 0;
    legal = cfg_load && (int'(cfg_len) >= 1) && (int'(cfg_len) <= MAX_LEN);
    if (legal) begin
      m_pat = cfg_pattern;
      m_len = int'(cfg_len);
      hq.delete();
      fresh = 0;
    end else begin
      if (cfg_load) m_err = 1;
      if (en) begin
        hq.push_back(x);
        if (hq.size() > MAX_LEN) void'(hq.pop_front());
        fresh++;
        if (fresh >= m_len) begin
          hit = 1;
          for (int j = 0; j < m_len; j++)
            if (hq[hq.size()-1-j] != m_pat[j]) hit = 0;
        end
        if (hit && !overlap) fresh = 0;
        m_z = hit;
      end
    end
    if (cnt_clr) m_cnt = 0;
    else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  // Advance one clock, update the model and compare every output.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("z", z, m_z);
    check_val("cfg_err", cfg_err, m_err);
    check_val("match_cnt", match_cnt, m_cnt);
    zcnt += z;
    ecnt += cfg_err;
  endtask

  task automatic send_bit(input bit b);
    en = 1'b1;
    x  = b;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    en          = 1'b0;
    tick();
    cfg_load    = 1'b0;
  endtask

  // Asynchronous reset issued mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_val("rst_z", z, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    check_val("rst_cnt", match_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; x = 1'b0; overlap = 1'b1;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("init_z", z, 0);
    check_val("init_cfg_err", cfg_err, 0);
    check_val("init_cnt", match_cnt, 0);
    reset_n = 1'b1;

    // Default 10110, overlapping: hits after bits 5 and 8.
    overlap = 1'b1; zcnt = 0;
    send_bits(32'b1011_0110, 8);
    check_val("t1_hits", zcnt, 2);
    check_val("t1_cnt", match_cnt, 2);

    // Same stream, non-overlapping: only after bit 5.
    do_reset();
    overlap = 1'b0; zcnt = 0;
    send_bits(32'b1011_0110, 8);
    check_val("t2_hits", zcnt, 1);
    check_val("t2_cnt", match_cnt, 1);

    // Full-length pattern 11110000, two back-to-back bytes.
    overlap = 1'b1;
    load_cfg(8'b1111_0000, LEN_W'(8));
    zcnt = 0;
    send_bits(32'hF0F0, 16);
    check_val("t3_hits", zcnt, 2);
    // Same bytes with en idle on alternate cycles: same hits, never during en=0 slots.
    zcnt = 0;
    for (int i = 15; i >= 0; i--) begin
      en = 1'b0; x = $urandom_range(0, 1);
      tick();
      check_val("t3_gap_z", z, 0);
      send_bit(i >= 8 ? 1'b1 - (i < 12) : 1'b1 - (i < 4));
    end
    check_val("t3_gap_hits", zcnt, 2);

    // Illegal lengths are rejected and the default pattern survives.
    do_reset();
    ecnt = 0;
    load_cfg(8'hFF, LEN_W'(0));
    load_cfg(8'hFF, LEN_W'(MAX_LEN + 1));
    check_val("t4_errs", ecnt, 2);
    zcnt = 0;
    send_bits(32'b10110, 5);
    check_val("t4_hits", zcnt, 1);

    // Counter saturation with len=1, then clear colliding with a hit.
    load_cfg(8'h01, LEN_W'(1));
    for (int i = 0; i < (1 << CNT_W) + 3; i++) send_bit(1'b1);
    check_val("t5_sat", match_cnt, (1 << CNT_W) - 1);
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    check_val("t5_clr_cnt", match_cnt, 0);
    check_val("t5_clr_z", z, 1);

    // Reset in the middle of 1011: the trailing 0 alone must not complete a match.
    do_reset();
    overlap = 1'b1;
    send_bits(32'b1011, 4);
    do_reset();
    zcnt = 0;
    send_bit(1'b0);
    check_val("t6_no_hit", zcnt, 0);
    send_bits(32'b10110, 5);
    check_val("t6_hit", zcnt, 1);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      x       = $urandom_range(0, 1);
      cnt_clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) overlap = $urandom_range(0, 1);
      cfg_load = ($urandom_range(0, 39) == 0);
      cfg_pattern = MAX_LEN'($urandom);
      if ($urandom_range(0, 1) == 1) cfg_len = LEN_W'($urandom_range(1, 4));
      else                           cfg_len = LEN_W'($urandom_range(0, MAX_LEN + 1));
      tick();
    end
    cfg_load = 1'b0; cnt_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
